// File: rtl/alu_pkg.sv
// Shared op codes, compare modes and FSM states for the sequential ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_NOR  = 3'd4,
    OP_NAND = 3'd5,
    OP_CMP  = 3'd6,
    OP_MUL  = 3'd7
  } op_e;

  localparam logic [2:0] CMP_LT = 3'b000;
  localparam logic [2:0] CMP_GT = 3'b001;
  localparam logic [2:0] CMP_LE = 3'b010;
  localparam logic [2:0] CMP_GE = 3'b011;
  localparam logic [2:0] CMP_EQ = 3'b100;
  localparam logic [2:0] CMP_NE = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational datapath for the single-cycle ops (logic, add/sub, compare).
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter bit          SIGNED_CMP = 1'b1
) (
  input  logic [2:0]       op,
  input  logic [2:0]       comp,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result_c,
  output logic             cout_c,
  output logic             overflow_c
);

  localparam int unsigned SW = WIDTH + 1;

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [SW-1:0]    sum_ext;
  logic             carry_msb;
  logic             ovf;
  logic             lt;
  logic             eq;
  logic             cmp_bit;

  // One adder serves ADD, SUB and CMP; everything except ADD subtracts.
  assign sub       = (op != OP_ADD);
  assign b_eff     = sub ? ~b : b;
  assign sum_ext   = {1'b0, a} + {1'b0, b_eff} + SW'(sub);
  assign carry_msb = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum_ext[WIDTH-1];
  assign ovf       = carry_msb ^ sum_ext[WIDTH];
  assign eq        = (a == b);
  // Signed: sign of difference corrected by overflow; unsigned: borrow.
  assign lt        = SIGNED_CMP ? (sum_ext[WIDTH-1] ^ ovf) : ~sum_ext[WIDTH];

  // Compare-mode decode; reserved modes yield 0.
  always_comb begin
    cmp_bit = 1'b0;
    case (comp)
      CMP_LT:  cmp_bit = lt;
      CMP_GT:  cmp_bit = ~lt & ~eq;
      CMP_LE:  cmp_bit = lt | eq;
      CMP_GE:  cmp_bit = ~lt;
      CMP_EQ:  cmp_bit = eq;
      CMP_NE:  cmp_bit = ~eq;
      default: cmp_bit = 1'b0;
    endcase
  end

  // Result and flag select; flags only meaningful for ADD/SUB.
  always_comb begin
    result_c   = '0;
    cout_c     = 1'b0;
    overflow_c = 1'b0;
    case (op)
      OP_AND:  result_c = a & b;
      OP_OR:   result_c = a | b;
      OP_NOR:  result_c = ~(a | b);
      OP_NAND: result_c = ~(a & b);
      OP_ADD, OP_SUB: begin
        result_c   = sum_ext[WIDTH-1:0];
        cout_c     = sum_ext[WIDTH];
        overflow_c = ovf;
      end
      OP_CMP:  result_c = {{(WIDTH-1){1'b0}}, cmp_bit};
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Registered multi-mode ALU with valid/ready handshake and iterative multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter bit          SIGNED_CMP = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic [2:0]       comp_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state, state_d;
  logic             ready_d, valid_d, zero_d, cout_d, ovf_d;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] mcand, mcand_d, mplier, mplier_d, acc, acc_d, acc_step;
  logic [CW-1:0]    count, count_d;
  logic [WIDTH-1:0] alu_result_c;
  logic             alu_cout_c, alu_ovf_c;

  alu_comb #(
    .WIDTH      (WIDTH),
    .SIGNED_CMP (SIGNED_CMP)
  ) u_comb (
    .op         (op_i),
    .comp       (comp_i),
    .a          (src1_i),
    .b          (src2_i),
    .result_c   (alu_result_c),
    .cout_c     (alu_cout_c),
    .overflow_c (alu_ovf_c)
  );

  // Only the low half of the product is kept, so a WIDTH-bit accumulator suffices.
  assign acc_step = acc + (mplier[0] ? mcand : '0);

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      ready_o    <= 1'b1;
      valid_o    <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      count      <= '0;
    end else begin
      state      <= state_d;
      ready_o    <= ready_d;
      valid_o    <= valid_d;
      result_o   <= result_d;
      zero_o     <= zero_d;
      cout_o     <= cout_d;
      overflow_o <= ovf_d;
      mcand      <= mcand_d;
      mplier     <= mplier_d;
      acc        <= acc_d;
      count      <= count_d;
    end
  end

  // Next-state, multiply iteration and result capture.
  always_comb begin
    state_d  = state;
    ready_d  = ready_o;
    valid_d  = valid_o;
    result_d = result_o;
    zero_d   = zero_o;
    cout_d   = cout_o;
    ovf_d    = overflow_o;
    mcand_d  = mcand;
    mplier_d = mplier;
    acc_d    = acc;
    count_d  = count;
    case (state)
      ST_IDLE: begin
        if (valid_i) begin
          ready_d = 1'b0;
          if (op_i == OP_MUL) begin
            mcand_d  = src1_i;
            mplier_d = src2_i;
            acc_d    = '0;
            count_d  = CW'(WIDTH);
            state_d  = ST_MUL;
          end else begin
            result_d = alu_result_c;
            zero_d   = (alu_result_c == '0);
            cout_d   = alu_cout_c;
            ovf_d    = alu_ovf_c;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand << 1;
        mplier_d = mplier >> 1;
        count_d  = count - CW'(1);
        if (count == CW'(1)) begin
          result_d = acc_step;
          zero_d   = (acc_step == '0);
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ready_i) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32, signed and unsigned compare).
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk, rst, valid_i, ready_i;
  logic [2:0]  op, comp;
  logic [31:0] src1, src2;
  logic        ready, valid_o, zero, cout, ovf;
  logic [31:0] result;
  logic        u_ready, u_valid, u_zero, u_cout, u_ovf;
  logic [31:0] u_result;
  int          n_checks, n_fail;

  alu_seq #(.WIDTH(32), .SIGNED_CMP(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready),
    .op_i(op), .comp_i(comp), .src1_i(src1), .src2_i(src2),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result),
    .zero_o(zero), .cout_o(cout), .overflow_o(ovf)
  );

  alu_seq #(.WIDTH(32), .SIGNED_CMP(1'b0)) dut_u (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(u_ready),
    .op_i(op), .comp_i(comp), .src1_i(src1), .src2_i(src2),
    .valid_o(u_valid), .ready_i(ready_i), .result_o(u_result),
    .zero_o(u_zero), .cout_o(u_cout), .overflow_o(u_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Present one request for exactly one edge; called and returns at posedge+1.
  task automatic issue(input logic [2:0] o, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    op = o; comp = c; src1 = a; src2 = b; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic consume();
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_checks++; if (u_ready !== 1'b1) begin n_fail++; $display("FAIL reset_u_ready: got %b want 1", u_ready); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_checks++; if ({result, zero, cout, ovf} !== 35'd0) begin n_fail++; $display("FAIL reset_outputs: got %h %b%b%b want 0", result, zero, cout, ovf); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ready !== 1'b1 || valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got ready=%b valid=%b want 1/0", ready, valid_o); end
  endtask

  task automatic test_add();
    issue(OP_ADD, 3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL add_latency: valid got %b want 1", valid_o); end
    n_checks++; if (result !== 32'h8000_0000) begin n_fail++; $display("FAIL add_result: got %h want 80000000", result); end
    n_checks++; if ({ovf, cout, zero} !== 3'b100) begin n_fail++; $display("FAIL add_flags: got ovf/cout/zero=%b%b%b want 100", ovf, cout, zero); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL add_ready_done: got %b want 0", ready); end
    consume();
  endtask

  task automatic test_sub();
    issue(OP_SUB, 3'd0, 32'd5, 32'd5);
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL sub_eq_result: got %h want 0", result); end
    n_checks++; if ({zero, cout, ovf} !== 3'b110) begin n_fail++; $display("FAIL sub_eq_flags: got zero/cout/ovf=%b%b%b want 110", zero, cout, ovf); end
    consume();
    issue(OP_SUB, 3'd0, 32'd0, 32'd1);
    n_checks++; if (result !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sub_borrow_result: got %h want ffffffff", result); end
    n_checks++; if ({zero, cout, ovf} !== 3'b000) begin n_fail++; $display("FAIL sub_borrow_flags: got zero/cout/ovf=%b%b%b want 000", zero, cout, ovf); end
    consume();
  endtask

  task automatic test_logic();
    logic [2:0]  ops [4];
    logic [31:0] exp [4];
    ops = '{OP_AND, OP_OR, OP_NOR, OP_NAND};
    exp = '{32'h00F0_1200, 32'hFFF0_FF34, 32'h000F_00CB, 32'hFF0F_EDFF};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 3'd0, 32'hF0F0_1234, 32'h0FF0_FF00);
      n_checks++; if (result !== exp[i] || cout !== 1'b0 || ovf !== 1'b0)
        begin n_fail++; $display("FAIL logic_op%0d: got %h c%b v%b want %h c0 v0", ops[i], result, cout, ovf, exp[i]); end
      consume();
    end
  endtask

  task automatic test_cmp();
    issue(OP_CMP, CMP_LT, 32'h8000_0000, 32'h0000_0001);
    n_checks++; if (result !== 32'd1 || zero !== 1'b0) begin n_fail++; $display("FAIL cmp_lt_signed: got %h z%b want 1 z0", result, zero); end
    n_checks++; if (u_valid !== 1'b1 || u_result !== 32'd0 || u_zero !== 1'b1) begin n_fail++; $display("FAIL cmp_lt_unsigned: got v%b %h z%b want v1 0 z1", u_valid, u_result, u_zero); end
    n_checks++; if ({cout, ovf, u_cout, u_ovf} !== 4'b0000) begin n_fail++; $display("FAIL cmp_flags: got %b%b%b%b want 0000", cout, ovf, u_cout, u_ovf); end
    consume();
    issue(OP_CMP, CMP_GT, 32'h0000_0001, 32'h8000_0000);
    n_checks++; if (result !== 32'd1) begin n_fail++; $display("FAIL cmp_gt_signed: got %h want 1", result); end
    consume();
    issue(OP_CMP, CMP_EQ, 32'd7, 32'd7);
    n_checks++; if (result !== 32'd1 || u_result !== 32'd1) begin n_fail++; $display("FAIL cmp_eq: got %h/%h want 1/1", result, u_result); end
    consume();
    issue(OP_CMP, CMP_GE, 32'hFFFF_FFFF, 32'h0000_0000);
    n_checks++; if (result !== 32'd0 || u_result !== 32'd1) begin n_fail++; $display("FAIL cmp_ge: got %h/%h want 0/1", result, u_result); end
    consume();
    issue(OP_CMP, 3'b110, 32'd7, 32'd7);
    n_checks++; if (result !== 32'd0 || zero !== 1'b1) begin n_fail++; $display("FAIL cmp_reserved: got %h z%b want 0 z1", result, zero); end
    consume();
  endtask

  task automatic test_mul();
    int k;
    issue(OP_MUL, 3'd0, 32'h0001_2345, 32'h0000_0100);
    n_checks++; if (ready !== 1'b0 || valid_o !== 1'b0) begin n_fail++; $display("FAIL mul_busy: got ready=%b valid=%b want 0/0", ready, valid_o); end
    k = 0;
    while (valid_o !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    n_checks++; if (k != 32) begin n_fail++; $display("FAIL mul_latency: got %0d cycles want 32", k); end
    n_checks++; if (result !== 32'h0123_4500 || zero !== 1'b0) begin n_fail++; $display("FAIL mul_result: got %h z%b want 01234500 z0", result, zero); end
    consume();
    issue(OP_MUL, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    k = 0;
    while (valid_o !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    n_checks++; if (k != 32 || result !== 32'h0000_0001 || cout !== 1'b0 || ovf !== 1'b0)
      begin n_fail++; $display("FAIL mul_wrap: got %h after %0d cycles c%b v%b want 00000001 after 32 c0 v0", result, k, cout, ovf); end
    consume();
  endtask

  task automatic test_back_to_back();
    issue(OP_ADD, 3'd0, 32'd3, 32'd4);
    op = OP_ADD; src1 = 32'd100; src2 = 32'd200; valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++; if (valid_o !== 1'b1 || result !== 32'd7 || ready !== 1'b0 || {zero, cout, ovf} !== 3'b000)
        begin n_fail++; $display("FAIL hold_cycle%0d: got v%b %h r%b flags %b%b%b want v1 7 r0 000", i, valid_o, result, ready, zero, cout, ovf); end
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    n_checks++; if (valid_o !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL release_idle: got v%b r%b want v0 r1", valid_o, ready); end
    @(posedge clk); #1;
    valid_i = 1'b0;
    n_checks++; if (valid_o !== 1'b1 || result !== 32'd300) begin n_fail++; $display("FAIL next_accept: got v%b %h want v1 0000012c", valid_o, result); end
    consume();
  endtask

  task automatic test_reset_mul();
    int stale;
    issue(OP_MUL, 3'd0, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (ready !== 1'b1 || valid_o !== 1'b0) begin n_fail++; $display("FAIL mulrst_state: got r%b v%b want r1 v0", ready, valid_o); end
    n_checks++; if ({result, zero, cout, ovf} !== 35'd0) begin n_fail++; $display("FAIL mulrst_outputs: got %h %b%b%b want 0", result, zero, cout, ovf); end
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid_o !== 1'b0 || result !== 32'd0) stale++;
    end
    n_checks++; if (stale != 0) begin n_fail++; $display("FAIL mulrst_stale: got %0d bad cycles want 0", stale); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    op = 3'd0; comp = 3'd0; src1 = '0; src2 = '0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_cmp();
    test_mul();
    test_back_to_back();
    test_reset_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
